// File: rtl/vga_digit_renderer.sv
// Draws NUM_DIGITS hex digits as 7-segment glyphs behind the VGA timing generator.
// Optional build macro VGA_DIGIT_BLINK_EN adds a 2-bit per-slot attribute with frame-rate blink.
module vga_digit_renderer #(
   parameter int          NUM_DIGITS = 8,
   parameter int          X0         = 64,
   parameter int          Y0         = 208,
   parameter int          PITCH      = 64,
   parameter int          DIGIT_W    = 40,
   parameter int          DIGIT_H    = 64,
   parameter int          SEG_T      = 6,
   parameter logic [23:0] FG_RGB     = 24'h00FF00,
   parameter logic [23:0] BG_RGB     = 24'h000000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [8:0] row,
   input  logic [9:0] col,
   input  logic       blank,
   input  logic       HS,
   input  logic       VS,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [2:0] wr_idx,
   input  logic [3:0] wr_digit,
`ifdef VGA_DIGIT_BLINK_EN
   input  logic [1:0] wr_vis,
`else
   input  logic       wr_vis,
`endif
   output logic       dirty,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       HS_out,
   output logic       VS_out,
   output logic       blank_out
);

`ifdef VGA_DIGIT_BLINK_EN
   localparam int VIS_W = 2;
`else
   localparam int VIS_W = 1;
`endif
   localparam int SLOT_W = VIS_W + 4;
   localparam int SHIFT  = $clog2(PITCH);

   localparam logic [10:0] X_LO  = 11'(X0);
   localparam logic [10:0] X_HI  = 11'(X0 + NUM_DIGITS * PITCH);
   localparam logic [10:0] Y_LO  = 11'(Y0);
   localparam logic [10:0] Y_HI  = 11'(Y0 + DIGIT_H);
   localparam logic [10:0] XMASK = 11'(PITCH - 1);
   localparam logic [10:0] W_LIM = 11'(DIGIT_W);
   localparam logic [10:0] T_LIM = 11'(SEG_T);
   localparam logic [10:0] W_T   = 11'(DIGIT_W - SEG_T);
   localparam logic [10:0] H_T   = 11'(DIGIT_H - SEG_T);
   localparam logic [10:0] H_MID = 11'(DIGIT_H / 2);
   localparam logic [10:0] G_LO  = 11'(DIGIT_H / 2 - SEG_T / 2);
   localparam logic [10:0] G_HI  = 11'(DIGIT_H / 2 + SEG_T / 2);

   // Segment mask, bit 0 = a ... bit 6 = g.
   function automatic logic [6:0] seg_mask(input logic [3:0] d);
      logic [6:0] m;
      case (d)
         4'h0:    m = 7'b0111111;
         4'h1:    m = 7'b0000110;
         4'h2:    m = 7'b1011011;
         4'h3:    m = 7'b1001111;
         4'h4:    m = 7'b1100110;
         4'h5:    m = 7'b1101101;
         4'h6:    m = 7'b1111101;
         4'h7:    m = 7'b0000111;
         4'h8:    m = 7'b1111111;
         4'h9:    m = 7'b1101111;
         4'hA:    m = 7'b1110111;
         4'hB:    m = 7'b1111100;
         4'hC:    m = 7'b0111001;
         4'hD:    m = 7'b1011110;
         4'hE:    m = 7'b1111001;
         4'hF:    m = 7'b1110001;
         default: m = 7'b0000000;
      endcase
      return m;
   endfunction

   logic [SLOT_W-1:0] shadow_r  [NUM_DIGITS];
   logic [SLOT_W-1:0] display_r [NUM_DIGITS];
   logic              vs_prev_r;
   logic              commit_s;
   logic              idx_ok_s;
   logic              wr_fire_s;

   assign commit_s  = vs_prev_r & ~VS;
   assign wr_ready  = ~commit_s;
   assign idx_ok_s  = ({1'b0, wr_idx} < 4'(NUM_DIGITS));
   assign wr_fire_s = wr_valid & wr_ready;

   // Shadow writes, once-per-frame commit to display, dirty tracking.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_r[i]  <= '0;
            display_r[i] <= '0;
         end
         vs_prev_r <= 1'b1;
         dirty     <= 1'b0;
      end else begin
         vs_prev_r <= VS;
         if (commit_s) begin
            display_r <= shadow_r;
            dirty     <= 1'b0;
         end else if (wr_fire_s && idx_ok_s) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (wr_idx == 3'(i)) begin
                  shadow_r[i] <= {wr_vis, wr_digit};
               end
            end
            dirty <= 1'b1;
         end
      end
   end

`ifdef VGA_DIGIT_BLINK_EN
   logic [5:0] frame_cnt_r;

   // Frame counter paces blink: bit 5 gives 32 frames on, 32 off.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         frame_cnt_r <= 6'd0;
      end else if (commit_s) begin
         frame_cnt_r <= frame_cnt_r + 6'd1;
      end
   end
`endif

   // Stage 1: glyph-local coordinates, widened to 11 bits so nothing wraps.
   logic [10:0] col_w_s, row_w_s, dx_s, dy_s, xi_s, slot_s;
   logic        in_box_s;

   assign col_w_s  = {1'b0, col};
   assign row_w_s  = {2'b00, row};
   assign dx_s     = col_w_s - X_LO;
   assign dy_s     = row_w_s - Y_LO;
   assign xi_s     = dx_s & XMASK;
   assign slot_s   = dx_s >> SHIFT;
   assign in_box_s = (col_w_s >= X_LO) && (col_w_s < X_HI) && (xi_s < W_LIM) &&
                     (row_w_s >= Y_LO) && (row_w_s < Y_HI);

   logic [10:0] slot_r, xi_r, yi_r;
   logic        in_box_r, blank_d1_r, hs_d1_r, vs_d1_r;

   // Stage 1 register.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         slot_r     <= 11'd0;
         xi_r       <= 11'd0;
         yi_r       <= 11'd0;
         in_box_r   <= 1'b0;
         blank_d1_r <= 1'b1;
         hs_d1_r    <= 1'b1;
         vs_d1_r    <= 1'b1;
      end else begin
         slot_r     <= slot_s;
         xi_r       <= xi_s;
         yi_r       <= dy_s;
         in_box_r   <= in_box_s;
         blank_d1_r <= blank;
         hs_d1_r    <= HS;
         vs_d1_r    <= VS;
      end
   end

   logic [SLOT_W-1:0] sel_s;
   logic [6:0]        region_s;
   logic              vis_s;
   logic              lit_s;
   logic [23:0]       rgb_next_s;

   // Stage 2: slot lookup, segment regions and colour select.
   always_comb begin
      sel_s = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         sel_s = (slot_r == 11'(i)) ? display_r[i] : sel_s;
      end
`ifdef VGA_DIGIT_BLINK_EN
      vis_s = (sel_s[5:4] == 2'b01) || (sel_s[5] && !frame_cnt_r[5]);
`else
      vis_s = sel_s[4];
`endif
      region_s[0] = (yi_r < T_LIM);
      region_s[1] = (xi_r >= W_T) && (yi_r < H_MID);
      region_s[2] = (xi_r >= W_T) && (yi_r >= H_MID);
      region_s[3] = (yi_r >= H_T);
      region_s[4] = (xi_r < T_LIM) && (yi_r >= H_MID);
      region_s[5] = (xi_r < T_LIM) && (yi_r < H_MID);
      region_s[6] = (yi_r >= G_LO) && (yi_r < G_HI);
      lit_s = in_box_r && vis_s && (|(region_s & seg_mask(sel_s[3:0])));
      if (blank_d1_r) begin
         rgb_next_s = 24'h000000;
      end else if (lit_s) begin
         rgb_next_s = FG_RGB;
      end else begin
         rgb_next_s = BG_RGB;
      end
   end

   logic [23:0] rgb_r;

   // Stage 2 register drives every output so colour and syncs stay aligned.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         rgb_r     <= 24'h000000;
         HS_out    <= 1'b1;
         VS_out    <= 1'b1;
         blank_out <= 1'b1;
      end else begin
         rgb_r     <= rgb_next_s;
         HS_out    <= hs_d1_r;
         VS_out    <= vs_d1_r;
         blank_out <= blank_d1_r;
      end
   end

   assign VGA_R = rgb_r[23:16];
   assign VGA_G = rgb_r[15:8];
   assign VGA_B = rgb_r[7:0];

endmodule

// File: tb/tb_vga_digit_renderer.sv
// Directed self-checking bench for vga_digit_renderer (default build), with a
// second NUM_DIGITS=4 instance for the out-of-range slot write.
module tb_vga_digit_renderer;
   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic [8:0] row = 9'd0;
   logic [9:0] col = 10'd0;
   logic       blank = 1'b1, HS = 1'b1, VS = 1'b1;
   logic       wr_valid = 1'b0;
   logic [2:0] wr_idx = 3'd0;
   logic [3:0] wr_digit = 4'd0;
   logic       wr_vis = 1'b0;

   logic       wr_ready, dirty, HS_out, VS_out, blank_out;
   logic [7:0] VGA_R, VGA_G, VGA_B;
   logic       wr_ready4, dirty4, HS_out4, VS_out4, blank_out4;
   logic [7:0] R4, G4, B4;

   int checks = 0;
   int errors = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   vga_digit_renderer dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .row(row), .col(col), .blank(blank),
      .HS(HS), .VS(VS), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
      .wr_digit(wr_digit), .wr_vis(wr_vis), .dirty(dirty), .VGA_R(VGA_R),
      .VGA_G(VGA_G), .VGA_B(VGA_B), .HS_out(HS_out), .VS_out(VS_out),
      .blank_out(blank_out));

   vga_digit_renderer #(.NUM_DIGITS(4)) dut4 (
      .CLOCK_50(CLOCK_50), .reset(reset), .row(row), .col(col), .blank(blank),
      .HS(HS), .VS(VS), .wr_valid(wr_valid), .wr_ready(wr_ready4), .wr_idx(wr_idx),
      .wr_digit(wr_digit), .wr_vis(wr_vis), .dirty(dirty4), .VGA_R(R4),
      .VGA_G(G4), .VGA_B(B4), .HS_out(HS_out4), .VS_out(VS_out4),
      .blank_out(blank_out4));

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write(input logic [2:0] idx, input logic vis, input logic [3:0] dig);
      wr_valid = 1'b1; wr_idx = idx; wr_vis = vis; wr_digit = dig;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic commit_frame();
      VS = 1'b0;
      tick();
      VS = 1'b1;
      tick();
   endtask

   task automatic pixel(input logic [8:0] r, input logic [9:0] c, input logic bl);
      row = r; col = c; blank = bl;
      tick();
      tick();
   endtask

   initial begin
      tick();
      tick();
      chk("reset_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
      chk("reset_hs_out", HS_out, 1'b1);
      chk("reset_vs_out", VS_out, 1'b1);
      chk("reset_blank_out", blank_out, 1'b1);
      chk("reset_dirty", dirty, 1'b0);
      reset = 1'b0;

      // All slots invisible after reset.
      VS = 1'b0; row = 9'd208; col = 10'd64; blank = 1'b0;
      tick();
      VS = 1'b1;
      tick();
      chk("invisible_g", VGA_G, 8'h00);
      chk("idle_dirty", dirty, 1'b0);
      chk("idle_wr_ready", wr_ready, 1'b1);

      // Digit 8 in slot 0 appears only after the commit.
      write(3'd0, 1'b1, 4'h8);
      chk("write_dirty", dirty, 1'b1);
      pixel(9'd208, 10'd64, 1'b0);
      chk("precommit_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
      commit_frame();
      chk("commit_dirty", dirty, 1'b0);
      pixel(9'd208, 10'd64, 1'b0);
      chk("digit8_corner_rgb", {VGA_R, VGA_G, VGA_B}, 24'h00FF00);

      // Segment g interior and the inter-glyph gap.
      write(3'd0, 1'b1, 4'h0);
      commit_frame();
      pixel(9'd240, 10'd80, 1'b0);
      chk("digit0_g_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
      pixel(9'd240, 10'd104, 1'b0);
      chk("digit0_gap_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
      write(3'd0, 1'b1, 4'h8);
      write(3'd1, 1'b1, 4'h1);
      commit_frame();
      pixel(9'd240, 10'd80, 1'b0);
      chk("digit8_g_rgb", {VGA_R, VGA_G, VGA_B}, 24'h00FF00);
      pixel(9'd240, 10'd104, 1'b0);
      chk("digit8_gap_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
      pixel(9'd218, 10'd167, 1'b0);
      chk("digit1_b_rgb", VGA_G, 8'hFF);
      pixel(9'd218, 10'd128, 1'b0);
      chk("digit1_f_rgb", VGA_G, 8'h00);

      // Write held across the commit cycle is stalled by one cycle.
      wr_valid = 1'b1; wr_idx = 3'd2; wr_vis = 1'b1; wr_digit = 4'h5; VS = 1'b0;
      #1;
      chk("commit_wr_ready", wr_ready, 1'b0);
      tick();
      chk("stalled_dirty", dirty, 1'b0);
      chk("after_commit_wr_ready", wr_ready, 1'b1);
      tick();
      chk("late_write_dirty", dirty, 1'b1);
      wr_valid = 1'b0; VS = 1'b1;
      tick();
      commit_frame();
      pixel(9'd208, 10'd192, 1'b0);
      chk("digit5_a_rgb", VGA_G, 8'hFF);

      // Blanking forces black; syncs are delayed exactly two clocks.
      pixel(9'd208, 10'd64, 1'b1);
      chk("blank_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
      chk("blank_out", blank_out, 1'b1);
      HS = 1'b0; VS = 1'b0;
      tick();
      chk("hs_d1", HS_out, 1'b1);
      chk("vs_d1", VS_out, 1'b1);
      tick();
      chk("hs_d2", HS_out, 1'b0);
      chk("vs_d2", VS_out, 1'b0);
      HS = 1'b1; VS = 1'b1;
      tick();
      chk("hs_rise_d1", HS_out, 1'b0);
      tick();
      chk("hs_rise_d2", HS_out, 1'b1);
      chk("vs_rise_d2", VS_out, 1'b1);

      // Out-of-range slot on the 4-digit instance is accepted and dropped.
      commit_frame();
      write(3'd7, 1'b1, 4'h3);
      chk("idx7_dirty_main", dirty, 1'b1);
      chk("idx7_dirty_4", dirty4, 1'b0);
      commit_frame();
      pixel(9'd208, 10'd64, 1'b0);
      chk("dut4_slot0_g", G4, 8'hFF);
      pixel(9'd208, 10'd512, 1'b0);
      chk("main_slot7_g", VGA_G, 8'hFF);
      chk("dut4_slot7_g", G4, 8'h00);

      // Mid-frame reset, then clean resume.
      write(3'd0, 1'b1, 4'h8);
      HS = 1'b0; VS = 1'b0; blank = 1'b0;
      reset = 1'b1;
      tick();
      chk("midreset_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
      chk("midreset_hs_out", HS_out, 1'b1);
      chk("midreset_vs_out", VS_out, 1'b1);
      chk("midreset_blank_out", blank_out, 1'b1);
      chk("midreset_dirty", dirty, 1'b0);
      reset = 1'b0; HS = 1'b1; VS = 1'b1;
      tick();
      commit_frame();
      pixel(9'd208, 10'd64, 1'b0);
      chk("resume_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_digit_renderer.md
Name: vga_digit_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA timing generator.
- Consumes the timing generator's row, col, blank, HS and VS, and draws a row of hex digits as 7-segment glyphs.
- Produces 8-bit R/G/B plus delayed sync and blank signals that stay aligned with the colour outputs.
- Digit values come in through a valid/ready write port into shadow registers; the shadow registers are copied to the display registers once per frame so digits never tear.

Parameters:
- NUM_DIGITS, 8: number of glyph slots, 1..8.
- X0, 64: leftmost column of digit 0.
- Y0, 208: top row of all digits.
- PITCH, 64: horizontal distance between glyph origins; must be a power of 2.
- DIGIT_W, 40: glyph width in pixels; must be less than PITCH.
- DIGIT_H, 64: glyph height in pixels; must be even.
- SEG_T, 6: segment thickness in pixels; must be even.
- FG_RGB, 24'h00FF00: colour of lit segments, as {R,G,B}.
- BG_RGB, 24'h000000: background colour inside the active area.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- row  in  9  pixel row from the timing generator.
- col  in  10  pixel column from the timing generator.
- blank  in  1  high outside the visible area.
- HS  in  1  horizontal sync, active low.
- VS  in  1  vertical sync, active low.
- wr_valid  in  1  write request.
- wr_ready  out  1  write may be accepted this cycle.
- wr_idx  in  3  target digit slot.
- wr_digit  in  4  hex value 0..F.
- wr_vis  in  1  1 = slot visible, 0 = slot drawn as background.
- dirty  out  1  shadow registers written since the last commit.
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour.
- HS_out, VS_out, blank_out  out  1 each  sync and blank delayed to match the colour outputs.

Behaviour:
- Clock and reset are fixed: single clock CLOCK_50; reset is synchronous and active-high.
- Reset values:
  - shadow and display registers: all digits 0, all slots invisible.
  - dirty = 0.
  - pipeline registers cleared, so VGA_R/G/B = 0.
  - HS_out = 1, VS_out = 1, blank_out = 1.
  - VS history register = 1.
- Write handshake:
  - A write transfers when wr_valid & wr_ready.
  - On transfer, shadow[wr_idx] <= {wr_vis, wr_digit} and dirty <= 1.
  - A write with wr_idx >= NUM_DIGITS is accepted and dropped; dirty is unchanged.
- Commit:
  - commit = vs_prev & ~VS, i.e. the falling edge of VS.
  - On the commit cycle, display <= shadow and dirty <= 0.
  - wr_ready = ~commit (combinational), so no write is ever accepted on the commit cycle.
  - Writes are otherwise accepted every cycle.
- Pipeline: 2 clocks of latency from row/col/blank/HS/VS to every output.
  - Stage 1 (registered):
    - dx = col - X0, dy = row - Y0.
    - slot = dx >> log2(PITCH), xi = dx & (PITCH-1), yi = dy.
    - in_box = col >= X0 && col < X0 + NUM_DIGITS*PITCH && xi < DIGIT_W && row >= Y0 && row < Y0 + DIGIT_H.
    - Compare on unsigned values widened to 11 bits; there is no wrap-around.
  - Stage 2 (registered):
    - Look up the display register for the slot, then the segment mask using the standard hex table: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
    - Segment regions, with H = DIGIT_H, W = DIGIT_W, T = SEG_T:
      - a: yi < T.
      - d: yi >= H-T.
      - g: H/2 - T/2 <= yi < H/2 + T/2.
      - f: xi < T && yi < H/2.
      - b: xi >= W-T && yi < H/2.
      - e: xi < T && yi >= H/2.
      - c: xi >= W-T && yi >= H/2.
    - lit = in_box & visible & (region ∩ mask nonzero).
    - Colour = blank ? 0 : (lit ? FG_RGB : BG_RGB).
- HS, VS and blank each pass through two flops.
- Reset asserted mid-frame: outputs go to their reset values on the next edge. Resume is clean: the next VS falling edge commits a fresh shadow.

Optional Feature:
- Macro: VGA_DIGIT_BLINK_EN.
- When defined:
  - wr_vis is replaced by a 2-bit attribute: 00 = hidden, 01 = visible, 1x = blink.
  - A 6-bit frame counter increments on every commit and resets to 0.
  - A blinking slot is lit only while counter[5] = 0 (32 frames on, 32 off).
- When undefined:
  - The counter is absent and the port is 1-bit wr_vis, as above.

Test Plan:
- Reset, then pulse VS low and drive row=208, col=64, blank=0 -> VGA_G = 8'h00 two clocks later (all slots invisible); dirty = 0; wr_ready = 1.
- Write idx 0 = {vis 1, digit 8} -> dirty = 1. Pixel row=208, col=64 still black before the VS falling edge. After the VS falling edge, the same pixel gives {R,G,B} = 00/FF/00 at +2 clocks and dirty = 0.
- Digit 0 visible in slot 0, pixel row=240, col=80 (segment g interior) -> black. Rewrite to 8 and commit -> green. Pixel col=104 (gap) -> black for both values.
- Hold wr_valid high across the VS falling-edge cycle -> wr_ready = 0 on exactly that cycle, no transfer; the write transfers on the following cycle and dirty = 1 afterwards.
- Slot 0 visible with digit 8; drive blank=1 with row=208, col=64 -> RGB = 0. HS_out and VS_out equal HS and VS delayed by exactly 2 clocks.
- wr_idx=7 with NUM_DIGITS=4 -> transfer occurs, dirty stays 0, display unchanged. With VGA_DIGIT_BLINK_EN defined, a blink slot is lit for frames 0-31 and dark for frames 32-63.
